// File: rtl/riscv_mem_pkg.sv
// Shared types for the multicycle CPU memory responder.
package riscv_mem_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  typedef enum logic [1:0] {FC_NONE, FC_CONFLICT, FC_MISALIGN} faultCause_e;

  // Classify a request. Read+write together takes priority over misalignment.
  function automatic faultCause_e faultCause(logic rd, logic wr, logic [1:0] lsb);
    if (rd && wr)        return FC_CONFLICT;
    else if (lsb != 2'b00) return FC_MISALIGN;
    else                 return FC_NONE;
  endfunction
endpackage

// File: rtl/mem_responder_array.sv
// Single-port word RAM: synchronous write, registered read, no reset.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [DEPTH];

  // Write on we, otherwise register the addressed word.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
    else    dout     <= mem[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory responder for the multicycle control unit: optional wait states,
// sticky fault on conflicting/misaligned requests, saturating access counter.
module mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0,
  parameter int AW          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        mem_ready,
  output logic        fault,
  output logic [15:0] access_count
);
  typedef struct packed {
    logic              isWrite;
    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] data;
  } req_t;

  state_e            state;
  req_t              latched, cur, acc;
  logic [2:0]        cnt;
  logic              accept, faulty, good, doAcc;
  logic [WORD_W-1:0] ramDout, rdataHold;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^addr[31:AW+2];

  assign accept = mem_ready && (MemRead || MemWrite);
  assign faulty = faultCause(MemRead, MemWrite, addr[1:0]) != FC_NONE;
  assign good   = accept && !faulty;
  assign cur    = '{isWrite: MemWrite, idx: addr[AW+1:2], data: wdata};

  // The RAM access happens on the edge entering RESP: straight from the
  // inputs when there are no wait states, else from the latched request.
  always_comb begin
    acc   = cur;
    doAcc = 1'b0;
    if (state == ST_WAIT) begin
      acc   = latched;
      doAcc = (cnt == 3'd0);
    end else if (WAIT_STATES == 0) begin
      doAcc = good;
    end
  end

  mem_array #(.DEPTH(DEPTH_WORDS), .AW(AW), .W(WORD_W)) uArray (
    .clk  (clk),
    .we   (doAcc && acc.isWrite),
    .idx  (acc.idx),
    .din  (acc.data),
    .dout (ramDout)
  );

  // RAM output is only meaningful in the rvalid cycle; hold it afterwards.
  assign rdata = rvalid ? ramDout : rdataHold;

  // FSM, request latch, wait counter, fault and access counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      latched      <= '0;
      cnt          <= 3'd0;
      rvalid       <= 1'b0;
      rdataHold    <= '0;
      mem_ready    <= 1'b1;
      fault        <= 1'b0;
      access_count <= '0;
    end else begin
      rvalid <= doAcc && !acc.isWrite;
      if (rvalid) rdataHold <= ramDout;
      if (doAcc && access_count != 16'hFFFF) access_count <= access_count + 16'd1;
      if (accept && faulty) fault <= 1'b1;
      case (state)
        ST_WAIT: begin
          if (cnt == 3'd0) begin
            state     <= ST_RESP;
            mem_ready <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          if (good) begin
            latched <= cur;
            if (WAIT_STATES == 0) begin
              state <= ST_RESP;
            end else begin
              state     <= ST_WAIT;
              cnt       <= 3'(WAIT_STATES - 1);
              mem_ready <= 1'b0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: one responder without wait states (d=0),
// one with three wait states (d=1), both against a word-array model.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rdat [2];
  logic        rv [2];
  logic        rdy [2];
  logic        flt [2];
  logic [15:0] acnt [2];

  int checks = 0;
  int failures = 0;

  // Model state
  logic [31:0] mMem [2][256];
  logic [31:0] mRd [2];
  int          mCnt [2];
  logic        mFlt [2];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .AW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd[0]), .MemWrite(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .rdata(rdat[0]), .rvalid(rv[0]), .mem_ready(rdy[0]),
    .fault(flt[0]), .access_count(acnt[0]));

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .AW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd[1]), .MemWrite(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .rdata(rdat[1]), .rvalid(rv[1]), .mem_ready(rdy[1]),
    .fault(flt[1]), .access_count(acnt[1]));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full output check against the model; rvalid expected as given.
  task automatic chkAll(int d, string tag, logic expRv);
    chk({tag, ".rvalid"}, 32'(rv[d]), 32'(expRv));
    chk({tag, ".ready"},  32'(rdy[d]), 32'd1);
    chk({tag, ".fault"},  32'(flt[d]), 32'(mFlt[d]));
    chk({tag, ".count"},  32'(acnt[d]), 32'(mCnt[d]));
    chk({tag, ".rdata"},  rdat[d], mRd[d]);
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      mRd[d] = 32'd0; mCnt[d] = 0; mFlt[d] = 1'b0;
    end
  endtask

  // One request, driven from a negedge; returns at the negedge of its response.
  task automatic req(int d, logic r, logic w, logic [31:0] a, logic [31:0] dat, string tag);
    logic       bad;
    logic [7:0] idx;
    bad = (r && w) || (a[1:0] != 2'b00);
    idx = a[9:2];
    rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = dat;
    @(posedge clk); #1;
    if (d == 1 && !bad) begin
      // random traffic during WAIT must be ignored, faulty or not
      rd[d] = 1'($urandom); wr[d] = 1'($urandom); ad[d] = $urandom; wd[d] = $urandom;
    end else begin
      rd[d] = 1'b0; wr[d] = 1'b0;
    end
    if (bad) begin
      mFlt[d] = 1'b1;
      @(negedge clk);
      chkAll(d, tag, 1'b0);
      return;
    end
    if (w) mMem[d][idx] = dat;
    else   mRd[d] = mMem[d][idx];
    if (mCnt[d] < 65535) mCnt[d]++;
    if (d == 1) begin
      repeat (3) begin
        @(negedge clk);
        chk({tag, ".waitReady"}, 32'(rdy[d]), 32'd0);
        chk({tag, ".waitRvalid"}, 32'(rv[d]), 32'd0);
      end
      rd[d] = 1'b0; wr[d] = 1'b0;
    end
    @(negedge clk);
    chkAll(d, tag, !w);
  endtask

  initial begin
    logic [31:0] a, v, old;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
    end
    resetModel();
    repeat (2) @(negedge clk);
    chkAll(0, "reset0", 1'b0);
    chkAll(1, "reset3", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // write then read back, count reaches 2
    req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "t1w");
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, "t1r");
    chk("t1.data", rdat[0], 32'hDEADBEEF);
    chk("t1.count", 32'(acnt[0]), 32'd2);

    // instruction fetch from word 0
    req(0, 1'b0, 1'b1, 32'h0, 32'h00000033, "t2w");
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, "t2r");
    chk("t2.data", rdat[0], 32'h00000033);

    // address wraps modulo 1 KiB
    req(0, 1'b0, 1'b1, 32'h400, 32'h12345678, "t5w");
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, "t5r");
    chk("t5.data", rdat[0], 32'h12345678);

    // fill both memories so every later read has a known value
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        req(d, 1'b0, 1'b1, 32'(i * 4), $urandom, "fill");

    // wait-state read of word 2
    req(1, 1'b1, 1'b0, 32'h8, 32'h0, "t3r");
    chk("t3.data", rdat[1], mMem[1][2]);

    // conflict then misaligned write; word 1 must survive
    req(0, 1'b1, 1'b1, 32'h4, 32'hBADBAD00, "t4rw");
    req(0, 1'b0, 1'b1, 32'h6, 32'hBADBAD01, "t4mis");
    req(0, 1'b1, 1'b0, 32'h4, 32'h0, "t4r");

    // random mix, including back-to-back and occasional faults
    for (int n = 0; n < 120; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      a = $urandom;
      v = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) req(d, 1'b1, 1'b1, {a[31:2], 2'b00}, v, "rndConf");
        else req(d, 1'($urandom), 1'b0, {a[31:2], 2'($urandom_range(1, 3))}, v, "rndMis");
      end else if ($urandom_range(0, 1) == 0) begin
        req(d, 1'b0, 1'b1, {a[31:2], 2'b00}, v, "rndW");
      end else begin
        req(d, 1'b1, 1'b0, {a[31:2], 2'b00}, v, "rndR");
      end
    end

    // reset during WAIT of a write abandons it
    a = {22'($urandom), 8'd77, 2'b00};
    old = mMem[1][77];
    rd[1] = 1'b0; wr[1] = 1'b1; ad[1] = a; wd[1] = ~old;
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    resetModel();
    chkAll(0, "t6rst0", 1'b0);
    chkAll(1, "t6rst3", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req(1, 1'b1, 1'b0, a, 32'h0, "t6r");
    chk("t6.data", rdat[1], old);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
